// File: rtl/bpu_upd_ctrl_pkg.sv
// Shared types and sizing for the BTB update scheduler.
package bpu_upd_ctrl_pkg;
    localparam int BR_WD         = 33;
    localparam int BPU_UPD_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
    } upd_t;
endpackage

// File: rtl/bpu_upd_ctrl_fifo.sv
// Circular update store: pointers, occupancy, and a per-entry pc match
// against the two incoming resolve ports.
module bpu_upd_fifo
    import bpu_upd_ctrl_pkg::*;
#(
    parameter int DEPTH = BPU_UPD_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic [1:0]            wr_cnt,
    input  upd_t [1:0]            wr_data,
    input  logic [1:0]            mrg_en,
    input  logic [1:0][AW-1:0]    mrg_idx,
    input  logic [1:0][31:0]      mrg_tgt,
    input  logic                  deq,
    input  logic [1:0][31:0]      cmp_pc,
    output upd_t                  head_data,
    output logic [AW-1:0]         head,
    output logic [CW-1:0]         count,
    output logic [1:0][DEPTH-1:0] match
);
    upd_t          mem [DEPTH];
    logic [AW-1:0] tail;

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + AW'(wr_cnt);
            count <= count + CW'(wr_cnt) - CW'(deq);
            if (deq) head <= head + AW'(1);
        end
    end

    // Merge targets are always live non-tail slots, so they never collide with enqueue writes.
    always_ff @(posedge clk) begin
        if (wr_cnt != 2'd0) mem[tail] <= wr_data[0];
        if (wr_cnt == 2'd2) mem[tail + AW'(1)] <= wr_data[1];
        for (int k = 0; k < 2; k++)
            if (mrg_en[k]) mem[mrg_idx[k]].target <= mrg_tgt[k];
    end

    assign head_data = mem[head];

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [AW-1:0] off;
        logic          live;
        assign off         = AW'(i) - head;
        assign live        = {1'b0, off} < count;
        assign match[0][i] = live && (mem[i].pc == cmp_pc[0]);
        assign match[1][i] = live && (mem[i].pc == cmp_pc[1]);
    end
endmodule

// File: rtl/bpu_upd_ctrl.sv
// Merges resolved taken-branch updates from two pipes into a single
// registered write stream for the BTB.
module bpu_upd_ctrl
    import bpu_upd_ctrl_pkg::*;
#(
    parameter int DEPTH = BPU_UPD_DEPTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             res0_valid,
    input  logic [31:0]      res0_pc,
    input  logic [31:0]      res0_target,
    input  logic             res1_valid,
    input  logic [31:0]      res1_pc,
    input  logic [31:0]      res1_target,
    input  logic             flush,
    output logic             res_ready,
    output logic [BR_WD-1:0] br_bus,
    output logic [31:0]      delayslot_pc,
    output logic             ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    upd_t                  in0, in1, head_data, issue;
    upd_t [1:0]            wr_data;
    logic                  v0, v1, busy, need0, need1, acc0, acc1, deq, drop, br_e;
    logic [1:0]            wr_cnt, mrg_en;
    logic [1:0][AW-1:0]    mrg_idx;
    logic [1:0][31:0]      mrg_tgt, cmp_pc;
    logic [1:0][DEPTH-1:0] match, cand;
    logic [AW-1:0]         head;
    logic [CW-1:0]         count, free;
    logic [31:0]           br_target;

    assign in0    = '{pc: res0_pc, target: res0_target};
    assign in1    = '{pc: res1_pc, target: res1_target};
    assign v0     = res0_valid && !(res1_valid && res0_pc == res1_pc);
    assign v1     = res1_valid;
    assign cmp_pc  = {res1_pc, res0_pc};
    assign mrg_tgt = {res1_target, res0_target};
    assign busy   = count != '0;

    // A non-empty queue always dequeues its head this cycle, so the head never absorbs a merge.
    assign cand[0] = match[0] & ~(DEPTH'(1) << head);
    assign cand[1] = match[1] & ~(DEPTH'(1) << head);

    always_comb begin
        mrg_idx = '0;
        for (int k = 0; k < 2; k++)
            for (int i = DEPTH - 1; i >= 0; i--)
                if (cand[k][i]) mrg_idx[k] = AW'(i);
    end

    assign mrg_en[0] = !flush && v0 && (|cand[0]);
    assign mrg_en[1] = !flush && v1 && (|cand[1]);
    assign need0     = v0 && !(|cand[0]);
    assign need1     = v1 && !(|cand[1]);

    // Slots are handed out oldest-first after accounting for this cycle's dequeue.
    assign free  = CW'(DEPTH) - count + CW'(busy);
    assign acc0  = need0 && (free != '0);
    assign acc1  = need1 && (free >= (acc0 ? CW'(2) : CW'(1)));
    assign drop  = !flush && ((need0 && !acc0) || (need1 && !acc1));

    assign wr_cnt     = flush ? 2'd0 : {1'b0, acc0} + {1'b0, acc1};
    assign wr_data[0] = acc0 ? in0 : in1;
    assign wr_data[1] = in1;
    assign deq        = !flush && (busy || acc0 || acc1);
    assign issue      = busy ? head_data : wr_data[0];

    bpu_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (flush),
        .wr_cnt   (wr_cnt),
        .wr_data  (wr_data),
        .mrg_en   (mrg_en),
        .mrg_idx  (mrg_idx),
        .mrg_tgt  (mrg_tgt),
        .deq      (deq),
        .cmp_pc   (cmp_pc),
        .head_data(head_data),
        .head     (head),
        .count    (count),
        .match    (match)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            br_e         <= 1'b0;
            br_target    <= '0;
            delayslot_pc <= '0;
            ovf          <= 1'b0;
        end else begin
            br_e <= deq;
            ovf  <= drop;
            if (deq) begin
                br_target    <= issue.target;
                delayslot_pc <= issue.pc;
            end
        end
    end

    assign br_bus    = {br_e, br_target};
    assign res_ready = (CW'(DEPTH) - count) >= CW'(2);
endmodule

// File: tb/tb_bpu_upd_ctrl.sv
// Self-checking bench: constant vector table, directed corner sequences and
// a randomized run against a queue-based reference model.
module tb_bpu_upd_ctrl;
    import bpu_upd_ctrl_pkg::*;
    localparam int DEPTH = 4;

    logic clk = 1'b0, resetn = 1'b0, flush = 1'b0;
    logic res0_valid = 1'b0, res1_valid = 1'b0;
    logic [31:0] res0_pc = '0, res0_target = '0, res1_pc = '0, res1_target = '0;
    logic res_ready, ovf;
    logic [BR_WD-1:0] br_bus;
    logic [31:0] delayslot_pc;

    bpu_upd_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .res0_valid(res0_valid), .res0_pc(res0_pc), .res0_target(res0_target),
        .res1_valid(res1_valid), .res1_pc(res1_pc), .res1_target(res1_target),
        .flush(flush), .res_ready(res_ready), .br_bus(br_bus),
        .delayslot_pc(delayslot_pc), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    upd_t mq[$];
    logic e_br_e, e_ovf, e_ready;
    logic [31:0] e_tgt, e_pc;

    typedef struct {
        logic v0; logic [31:0] p0, t0;
        logic v1; logic [31:0] p1, t1;
        logic x_e; logic [31:0] x_tgt, x_pc; logic x_rdy;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: the queue is a plain list; q[0] is the entry leaving this cycle.
    task automatic model_step(input logic v0, input logic [31:0] p0, t0,
                              input logic v1, input logic [31:0] p1, t1, input logic fl);
        upd_t nw[$];
        int free;
        bit drop;
        e_ovf = 1'b0;
        if (!resetn) begin
            mq.delete(); e_br_e = 1'b0; e_tgt = '0; e_pc = '0;
        end else if (fl) begin
            mq.delete(); e_br_e = 1'b0;
        end else begin
            if (v0 && v1 && p0 == p1) v0 = 1'b0;
            drop = 1'b0;
            for (int r = 0; r < 2; r++) begin
                upd_t u;
                bit hit;
                if (!(r == 0 ? v0 : v1)) continue;
                u.pc = (r == 0) ? p0 : p1;
                u.target = (r == 0) ? t0 : t1;
                hit = 1'b0;
                for (int j = 1; j < mq.size(); j++)
                    if (mq[j].pc == u.pc) begin mq[j].target = u.target; hit = 1'b1; end
                if (!hit) nw.push_back(u);
            end
            free = DEPTH - mq.size() + ((mq.size() > 0) ? 1 : 0);
            foreach (nw[k]) begin
                if (free > 0) begin mq.push_back(nw[k]); free--; end
                else drop = 1'b1;
            end
            e_ovf = drop;
            if (mq.size() > 0) begin
                upd_t h = mq.pop_front();
                e_br_e = 1'b1; e_tgt = h.target; e_pc = h.pc;
            end else e_br_e = 1'b0;
        end
        e_ready = ((DEPTH - mq.size()) >= 2);
    endtask

    task automatic step(input logic v0, input logic [31:0] p0, t0,
                        input logic v1, input logic [31:0] p1, t1, input logic fl);
        res0_valid = v0; res0_pc = p0; res0_target = t0;
        res1_valid = v1; res1_pc = p1; res1_target = t1;
        flush = fl;
        model_step(v0, p0, t0, v1, p1, t1, fl);
        @(posedge clk);
        @(negedge clk);
        chk("mdl_br_e", br_bus[32], e_br_e);
        chk("mdl_tgt", br_bus[31:0], e_tgt);
        chk("mdl_pc", delayslot_pc, e_pc);
        chk("mdl_ovf", ovf, e_ovf);
        chk("mdl_ready", res_ready, e_ready);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 32'hBFC00104, 32'hBFC00200, 1'b0, 32'h0, 32'h0, 1'b1, 32'hBFC00200, 32'hBFC00104, 1'b1};
        tbl[1] = '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'hBFC00200, 32'hBFC00104, 1'b1};
        tbl[2] = '{1'b1, 32'h80000010, 32'h80000100, 1'b1, 32'h80000010, 32'h80000200, 1'b1, 32'h80000200, 32'h80000010, 1'b1};
        tbl[3] = '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h80000200, 32'h80000010, 1'b1};
        tbl[4] = '{1'b1, 32'h100, 32'h1000, 1'b1, 32'h104, 32'h1004, 1'b1, 32'h1000, 32'h100, 1'b1};
        tbl[5] = '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1004, 32'h104, 1'b1};
        tbl[6] = '{1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1004, 32'h104, 1'b1};

        resetn = 1'b0;
        idle(); idle();
        chk("rst_br_e", br_bus[32], 1'b0);
        chk("rst_tgt", br_bus[31:0], 32'h0);
        chk("rst_pc", delayslot_pc, 32'h0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_ready", res_ready, 1'b1);
        resetn = 1'b1;
        idle(); idle();

        foreach (tbl[i]) begin
            step(tbl[i].v0, tbl[i].p0, tbl[i].t0, tbl[i].v1, tbl[i].p1, tbl[i].t1, 1'b0);
            chk($sformatf("tbl%0d_br_e", i), br_bus[32], tbl[i].x_e);
            chk($sformatf("tbl%0d_tgt", i), br_bus[31:0], tbl[i].x_tgt);
            chk($sformatf("tbl%0d_pc", i), delayslot_pc, tbl[i].x_pc);
            chk($sformatf("tbl%0d_ready", i), res_ready, tbl[i].x_rdy);
        end

        // Merge into a non-head queued entry.
        step(1'b1, 32'h200, 32'h2000, 1'b1, 32'h204, 32'h2004, 1'b0);
        step(1'b1, 32'h208, 32'h2008, 1'b1, 32'h20C, 32'h200C, 1'b0);
        step(1'b1, 32'h20C, 32'h3333, 1'b0, '0, '0, 1'b0);
        chk("mrg_head_pc", delayslot_pc, 32'h208);
        idle();
        chk("mrg_new_tgt", br_bus[31:0], 32'h3333);
        chk("mrg_new_pc", delayslot_pc, 32'h20C);
        idle();
        chk("mrg_single", br_bus[32], 1'b0);

        // A match on the departing head is enqueued as a fresh entry.
        step(1'b1, 32'h300, 32'h3000, 1'b1, 32'h304, 32'h3004, 1'b0);
        step(1'b1, 32'h304, 32'h4444, 1'b0, '0, '0, 1'b0);
        chk("hd_old_tgt", br_bus[31:0], 32'h3004);
        idle();
        chk("hd_new_e", br_bus[32], 1'b1);
        chk("hd_new_tgt", br_bus[31:0], 32'h4444);
        idle();

        // Fill to full with two new updates per cycle, ignoring res_ready.
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 32'h400 + 32'(8 * c), 32'hA00 + 32'(c), 1'b1, 32'h404 + 32'(8 * c), 32'hB00 + 32'(c), 1'b0);
            if (c == 1) chk("full_rdy_c2", res_ready, 1'b1);
            if (c == 2) chk("full_rdy_c3", res_ready, 1'b0);
            if (c == 3) chk("full_ovf_c4", ovf, 1'b0);
            if (c == 4) chk("full_ovf_c5", ovf, 1'b1);
        end
        for (int c = 0; c < 6; c++) idle();
        chk("full_drained", br_bus[32], 1'b0);

        // Pointer wrap with a 1-per-cycle stream.
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 32'h500 + 32'(4 * c), 32'hC00 + 32'(c), 1'b0, '0, '0, 1'b0);
            chk($sformatf("wrap%0d_pc", c), delayslot_pc, 32'h500 + 32'(4 * c));
        end
        idle();

        // Flush with three queued and two arriving.
        step(1'b1, 32'h540, 32'h1, 1'b1, 32'h544, 32'h2, 1'b0);
        step(1'b1, 32'h548, 32'h3, 1'b1, 32'h54C, 32'h4, 1'b0);
        step(1'b1, 32'h550, 32'h5, 1'b1, 32'h554, 32'h6, 1'b0);
        step(1'b1, 32'h558, 32'h7, 1'b1, 32'h55C, 32'h8, 1'b1);
        chk("fl_br_e", br_bus[32], 1'b0);
        chk("fl_ready", res_ready, 1'b1);
        idle();
        chk("fl_quiet", br_bus[32], 1'b0);
        step(1'b1, 32'h600, 32'h6000, 1'b0, '0, '0, 1'b0);
        chk("fl_new_e", br_bus[32], 1'b1);
        chk("fl_new_pc", delayslot_pc, 32'h600);

        // Reset mid-operation loses queued updates.
        step(1'b1, 32'h700, 32'h1, 1'b1, 32'h704, 32'h2, 1'b0);
        step(1'b1, 32'h708, 32'h3, 1'b1, 32'h70C, 32'h4, 1'b0);
        resetn = 1'b0;
        idle();
        chk("mrst_br_e", br_bus[32], 1'b0);
        chk("mrst_tgt", br_bus[31:0], 32'h0);
        resetn = 1'b1;
        idle();
        chk("mrst_lost", br_bus[32], 1'b0);

        // Randomized traffic over a small pc pool to provoke merges and overflow.
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 1)), 32'h800 + 32'(4 * $urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 32'h800 + 32'(4 * $urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 31) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bpu_upd_ctrl.md
# bpu_upd_ctrl

Update scheduler for the 8-entry branch target buffer, `bpu`. It collects resolved taken-branch updates from the two execute pipes and buffers them in a small queue. It merges duplicate updates and issues at most one registered update per cycle onto `bpu`'s `br_bus`/`delayslot_pc` inputs, so `bpu` sees a single clean write stream and never two writes in one cycle.

## Interface
- DEPTH, 4, queue entries; power of two, at least 2.
- clk  in  1  clock; all state updates on its rising edge.
- resetn  in  1  synchronous, active-low reset.
- res0_valid  in  1  pipe-0 (older) resolved branch is taken this cycle.
- res0_pc  in  32  pipe-0 delay-slot PC, used as the BTB tag.
- res0_target  in  32  pipe-0 branch target.
- res1_valid / res1_pc / res1_target  in  1/32/32  the same fields for pipe 1 (younger).
- flush  in  1  discard every queued, not-yet-issued update.
- res_ready  out  1  high when at least 2 entries are free; decoded from the registered count.
- br_bus  out  `BR_WD`  {br_e, br_target} to `bpu`; br_e is a one-cycle pulse per issued update.
- delayslot_pc  out  32  tag paired with br_bus, valid while br_e=1.
- ovf  out  1  one-cycle pulse when an update was dropped for lack of space.

## Operation
- Queue is a circular buffer of DEPTH entries {pc, target}, with head, tail and count.
- Per cycle, in this order:
  1. Merge the inputs. If both res*_valid are high and res0_pc == res1_pc, keep only res1; the younger target wins.
  2. Merge against the queue. An incoming update whose pc matches a queued entry overwrites that entry's target in place and consumes no slot.
     - Exception: the head entry being dequeued this cycle is not a merge candidate. A match on it is enqueued as a new entry.
  3. Enqueue the remaining updates at the tail, res0 before res1.
  4. Dequeue the head if count > 0.
- Enqueue and dequeue in the same cycle are legal; count changes by (enqueued − dequeued).
- Free space is counted after this cycle's dequeue.
- Full boundary:
  - If only one slot is free, res0 is accepted and res1 is dropped.
  - If no slot is free, both are dropped.
  - Any drop pulses ovf the next cycle. Producers must honour res_ready, so ovf is an error indicator only.
- Wrap: head and tail increment modulo DEPTH.
- Flush:
  - Takes effect at the clock edge: count, head and tail go to 0.
  - Same-cycle res*_valid inputs are discarded and no dequeue occurs.
  - br_e is 0 on the next cycle.
  - An update already on br_bus when flush is sampled is unaffected.
- Issue register: on a dequeue, the next cycle drives br_e=1, br_target = entry.target, delayslot_pc = entry.pc. Otherwise br_e=0 and the data fields hold their last value.

## Timing
- Reset values: br_e=0, br_target=0, delayslot_pc=0, ovf=0, count=0, head=tail=0, res_ready=1.
- Latency: an update arriving on an empty queue at cycle N appears on br_bus at N+1, because the arriving entry can be dequeued in the same cycle (bypass).
- Throughput: 1 issued update per cycle. Up to 2 accepted per cycle while space remains.
- res_ready in cycle N reflects the count after the N−1 edge. It has no combinational path from res*_valid.
- Reset asserted mid-operation clears all state at that edge; queued updates are lost.

## Structure
- The shared defines header (`lib/defines.vh`) holds `BR_WD` (=33). It also holds a new BPU_UPD_DEPTH default used for DEPTH.
- One sub-module, bpu_upd_fifo, covers storage, pointers, count and the CAM-style pc match vector.
- The merge, drop and issue logic stays in bpu_upd_ctrl.

## Test plan
- Single update: res0 {pc 0xBFC00104, tgt 0xBFC00200} at cycle 5 → br_e=1 at cycle 6 with those values; res_ready stays 1.
- Dual same-pc: res0 and res1 both pc 0x80000010, targets 0x80000100 and 0x80000200 → exactly one issue, target 0x80000200.
- Merge in queue: fill 3 distinct pcs, then resend the second pc with a new target → count stays 3; the second issue carries the new target.
- Full and overflow: DEPTH=4; present 2 new updates per cycle and ignore res_ready until full.
  - res_ready drops when count≥3.
  - The cycle with 1 free slot accepts res0 only and pulses ovf next cycle.
  - Issue order matches acceptance order.
- Wrap: stream 10 sequential updates at 1 per cycle → 10 issues in order; pointers wrap without loss.
- Flush: with 3 queued plus 2 arriving, assert flush → no br_e on the following cycles, count=0, res_ready=1. A subsequent new update issues with latency 1.
